// File: rtl/keypad_scan_ctrl.sv
// keypad_scan_ctrl: 4x4 matrix keypad scanner with debounced press/release and a two-key history.
module keypad_scan_ctrl #(
  parameter int SCAN_DIV     = 1000,
  parameter int DEBOUNCE_CYC = 20000
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic [3:0]  read_row,
  output logic [3:0]  scan_col,
  output logic [15:0] data_received,
  output logic        receive_ready,
  output logic        key_held
);
  typedef enum logic [1:0] {SCAN, DEBOUNCE, REPORT, WAIT_RELEASE} state_t;
  localparam logic [19:0] DIV_LAST = 20'(SCAN_DIV - 1);
  localparam logic [19:0] DEB      = 20'(DEBOUNCE_CYC);
  // Byte at bit offset {row,col,3'b000}: rows 0..3 from LSB, columns 0..3 within each row.
  localparam logic [127:0] CODES = 128'h0D23302A_0C393837_0B363534_0A333231;
  state_t      state, state_d;
  logic [3:0]  s1, rs;
  logic [1:0]  col, col_d, row, row_d;
  logic [19:0] cnt, cnt_d;
  logic [15:0] data_d;
  always_ff @(posedge clk or negedge nrst)
    if (!nrst) begin
      state         <= SCAN;
      s1            <= '0;
      rs            <= '0;
      col           <= '0;
      row           <= '0;
      cnt           <= '0;
      data_received <= '0;
    end else begin
      state         <= state_d;
      s1            <= read_row;
      rs            <= s1;
      col           <= col_d;
      row           <= row_d;
      cnt           <= cnt_d;
      data_received <= data_d;
    end
  // History is updated on entry to REPORT so the new code and the pulse appear together.
  always_comb begin
    state_d = state;
    col_d   = col;
    row_d   = row;
    cnt_d   = cnt + 20'd1;
    data_d  = data_received;
    case (state)
      SCAN:
        if (cnt == DIV_LAST) begin
          cnt_d = '0;
          if (rs == 4'd0) col_d = col + 2'd1;
          else begin
            row_d   = rs[0] ? 2'd0 : rs[1] ? 2'd1 : rs[2] ? 2'd2 : 2'd3;
            state_d = DEBOUNCE;
          end
        end
      DEBOUNCE:
        if (!rs[row]) begin
          state_d = SCAN;
          col_d   = col + 2'd1;
          cnt_d   = '0;
        end else if (cnt == DEB) begin
          state_d = REPORT;
          cnt_d   = '0;
          data_d  = {data_received[7:0], CODES[{row, col, 3'b000} +: 8]};
        end
      REPORT: begin
        state_d = WAIT_RELEASE;
        cnt_d   = '0;
      end
      WAIT_RELEASE:
        if (rs != 4'd0) cnt_d = '0;
        else if (cnt == DEB) begin
          state_d = SCAN;
          col_d   = col + 2'd1;
          cnt_d   = '0;
        end
    endcase
  end
  assign scan_col      = 4'b0001 << col;
  assign receive_ready = state == REPORT;
  assign key_held      = state == REPORT || state == WAIT_RELEASE;
endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// tb_keypad_scan_ctrl: directed checks of keypad_scan_ctrl against a column-gated keypad model.
module tb_keypad_scan_ctrl;
  logic        clk = 0, nrst;
  logic [3:0]  read_row, scan_col;
  logic [15:0] data_received;
  logic        receive_ready, key_held;
  logic [15:0] pressed;
  int checks = 0, errors = 0, pulses = 0, not_onehot = 0, p0, n;

  keypad_scan_ctrl #(.SCAN_DIV(4), .DEBOUNCE_CYC(8)) dut (
    .clk(clk), .nrst(nrst), .read_row(read_row), .scan_col(scan_col),
    .data_received(data_received), .receive_ready(receive_ready), .key_held(key_held)
  );

  always #5 clk = ~clk;

  // Key (row r, col c) is bit c*4+r of pressed; it only drives its row while its column is driven.
  always_comb begin
    read_row = '0;
    for (int c = 0; c < 4; c++) if (scan_col[c]) read_row |= pressed[c*4 +: 4];
  end

  always @(negedge clk) begin
    if (receive_ready) pulses++;
    if (nrst && !$onehot(scan_col)) not_onehot++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_ready(input string tag);
    n = 0;
    while (!receive_ready && n < 300) begin @(negedge clk); n++; end
    chk(tag, 32'(receive_ready), 32'd1);
  endtask

  task automatic wait_release(input string tag);
    n = 0;
    while (key_held && n < 100) begin @(negedge clk); n++; end
    chk(tag, 32'(key_held), 32'd0);
  endtask

  task automatic reset_pulse();
    nrst = 0;
    repeat (2) @(negedge clk);
    nrst = 1;
  endtask

  initial begin
    nrst = 0;
    pressed = '0;
    repeat (3) @(negedge clk);
    chk("rst_col", 32'(scan_col), 32'h1);
    chk("rst_data", 32'(data_received), 32'h0);
    chk("rst_ready", 32'(receive_ready), 32'h0);
    chk("rst_held", 32'(key_held), 32'h0);
    nrst = 1;
    for (int i = 0; i < 16; i++) begin
      repeat (4) @(negedge clk);
      chk($sformatf("idle_col%0d", i), 32'(scan_col), 32'(4'b0001 << ((i + 1) % 4)));
    end
    chk("idle_pulses", 32'(pulses), 32'd0);

    p0 = pulses;
    pressed = 16'h0020;
    wait_ready("k5_ready");
    chk("k5_data", 32'(data_received), 32'h0035);
    chk("k5_col", 32'(scan_col), 32'h2);
    chk("k5_held", 32'(key_held), 32'd1);
    @(negedge clk);
    chk("k5_single", 32'(receive_ready), 32'd0);
    repeat (39) @(negedge clk);
    pressed = '0;
    repeat (4) @(negedge clk);
    chk("k5_held_after_rel", 32'(key_held), 32'd1);
    wait_release("k5_release");
    chk("k5_pulses", 32'(pulses - p0), 32'd1);

    reset_pulse();
    p0 = pulses;
    pressed = 16'h0001;
    wait_ready("k1_ready");
    chk("k1_data", 32'(data_received), 32'h0031);
    repeat (20) @(negedge clk);
    pressed = '0;
    wait_release("k1_release");
    pressed = 16'h0800;
    wait_ready("khash_ready");
    chk("khash_data", 32'(data_received), 32'h3123);
    repeat (20) @(negedge clk);
    pressed = '0;
    wait_release("khash_release");
    chk("seq_pulses", 32'(pulses - p0), 32'd2);

    p0 = pulses;
    for (int i = 0; i < 40; i++) begin
      pressed = (i % 2 == 0) ? 16'h0020 : 16'h0000;
      repeat (3) @(negedge clk);
    end
    pressed = '0;
    repeat (20) @(negedge clk);
    chk("bounce_pulses", 32'(pulses - p0), 32'd0);
    chk("bounce_data", 32'(data_received), 32'h3123);
    chk("bounce_held", 32'(key_held), 32'd0);

    p0 = pulses;
    pressed = 16'h5000;
    wait_ready("multi_ready");
    chk("multi_data", 32'(data_received), 32'h230A);
    chk("multi_col", 32'(scan_col), 32'h8);
    repeat (30) @(negedge clk);
    pressed = 16'h4000;
    repeat (20) @(negedge clk);
    chk("multi_still_held", 32'(key_held), 32'd1);
    pressed = '0;
    wait_release("multi_release");
    chk("multi_pulses", 32'(pulses - p0), 32'd1);

    nrst = 0;
    pressed = 16'h0020;
    repeat (2) @(negedge clk);
    nrst = 1;
    repeat (10) @(negedge clk);
    nrst = 0;
    @(negedge clk);
    chk("mid_rst_col", 32'(scan_col), 32'h1);
    chk("mid_rst_data", 32'(data_received), 32'h0);
    chk("mid_rst_ready", 32'(receive_ready), 32'h0);
    chk("mid_rst_held", 32'(key_held), 32'h0);
    @(negedge clk);
    p0 = pulses;
    nrst = 1;
    repeat (12) @(negedge clk);
    chk("mid_rst_no_early", 32'(pulses - p0), 32'd0);
    wait_ready("mid_rst_ready2");
    chk("mid_rst_data2", 32'(data_received), 32'h0035);
    repeat (20) @(negedge clk);
    pressed = '0;
    wait_release("mid_rst_release");
    chk("mid_rst_pulses", 32'(pulses - p0), 32'd1);

    chk("onehot", 32'(not_onehot), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/keypad_scan_ctrl.md
KEYPAD_SCAN_CTRL -- requirements
Module: keypad_scan_ctrl

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 1000, meaning clk cycles each column is driven before its rows are sampled (legal 4..2^20-1).
REQ-002 SHALL have parameter DEBOUNCE_CYC, default 20000, meaning consecutive stable clk cycles required for press and release (legal 2..2^20-1).
REQ-003 SHALL have port clk  input  1  system clock, all state on rising edge.
REQ-004 SHALL have port nrst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port read_row  input  4  keypad row lines, active-high, asynchronous to clk.
REQ-006 SHALL have port scan_col  output  4  one-hot active-high column drive, bit i = column i.
REQ-007 SHALL have port data_received  output  16  key history: [7:0] newest key code, [15:8] previous key code.
REQ-008 SHALL have port receive_ready  output  1  single-cycle pulse, asserted in the cycle data_received changes.
REQ-009 SHALL have port key_held  output  1  high from REPORT until release debounce completes.

Function
REQ-010 SHALL pass read_row through a 2-flop synchronizer; all decisions SHALL use the synchronized value (rs).
REQ-011 SHALL implement states SCAN, DEBOUNCE, REPORT, WAIT_RELEASE.
REQ-012 SCAN: drive column c, count SCAN_DIV cycles; on last count, rs==0 -> c=(c+1) mod 4 (3 wraps to 0), counter cleared; rs!=0 -> capture row r = lowest set bit of rs, go DEBOUNCE with c unchanged.
REQ-013 DEBOUNCE: scan_col holds column c; each cycle rs==captured one-hot-or-superset with bit r set increments counter, else state returns to SCAN at column (c+1) mod 4 with no report.
REQ-014 DEBOUNCE SHALL go to REPORT on the cycle after the counter reaches DEBOUNCE_CYC.
REQ-015 REPORT (exactly one cycle): data_received <= {data_received[7:0], code(r,c)}, receive_ready=1, key_held=1, then WAIT_RELEASE.
REQ-016 Key codes (row r, column c): r0: 0x31 0x32 0x33 0x0A; r1: 0x34 0x35 0x36 0x0B; r2: 0x37 0x38 0x39 0x0C; r3: 0x2A('*') 0x30 0x23('#') 0x0D.
REQ-017 WAIT_RELEASE: column c held; counter increments while rs==0, clears on any rs!=0; at DEBOUNCE_CYC -> key_held=0, SCAN at column (c+1) mod 4.
REQ-018 Held key SHALL produce exactly one report; no auto-repeat.
REQ-019 Simultaneous keys in one column SHALL report lowest row only; keys in other columns SHALL be ignored until return to SCAN.
REQ-020 A second key pressed while first held (same column) SHALL not report and SHALL extend WAIT_RELEASE until all rows low.
REQ-021 Counters SHALL be 20 bits, saturate never reached under legal parameters; no wrap-around behaviour required.
REQ-022 scan_col SHALL be exactly one-hot in every cycle after reset.

Reset
REQ-023 nrst low SHALL immediately force: state SCAN, column 0, scan_col=4'b0001, counters 0, synchronizer 0, data_received=16'h0000, receive_ready=0, key_held=0.
REQ-024 Reset asserted mid-DEBOUNCE or mid-REPORT SHALL discard the pending key; no pulse after nrst release until a fresh full debounce.

Verification (SCAN_DIV=4, DEBOUNCE_CYC=8)
REQ-025 Idle: rows 0 for 64 cycles -> scan_col cycles 0001,0010,0100,1000,0001 every 4 cycles; receive_ready never high.
REQ-026 Press '5' (row1 when scan_col=0010) held 40 cycles then released -> one receive_ready pulse, data_received=16'h0035, key_held high until 8 cycles after release+sync.
REQ-027 Press '1' then '#' sequentially -> data_received 16'h0031 then 16'h3123, two pulses total.
REQ-028 Bounce: row toggles every 3 cycles during DEBOUNCE -> no pulse; data_received unchanged.
REQ-029 Rows 0 and 2 high together in column 3 -> code 0x0A reported once.
REQ-030 nrst pulsed low 2 cycles into DEBOUNCE -> outputs at reset values, no pulse; key still held afterwards reported once after full rescan+debounce.
